// File: rtl/noc_flit_ingress_buffer.sv
// Credit-returning flit ingress buffer: circular FIFO with a head/body packet tracker on the output.
// Optional input-side protocol checks are compiled in with NOC_FLIT_INGRESS_CHECK_EN.
module noc_flit_ingress_buffer #(
  parameter int FLIT_WIDTH        = 128,
  parameter int TDEST_WIDTH       = 3,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [TDEST_WIDTH-1:0] dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   flit_valid,
  input  logic                   flit_ready,
  output logic [FLIT_WIDTH-1:0]  flit_data,
  output logic [TDEST_WIDTH-1:0] flit_dest,
  output logic                   flit_tail,
  output logic                   flit_head,
  output logic                   err_overflow,
  output logic                   err_dest
);

  localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FLIT_BUFFER_DEPTH);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} pkt_state_e;

  logic [FLIT_WIDTH-1:0]  data_q [FLIT_BUFFER_DEPTH];
  logic [FLIT_WIDTH-1:0]  data_d [FLIT_BUFFER_DEPTH];
  logic [TDEST_WIDTH-1:0] dest_q [FLIT_BUFFER_DEPTH];
  logic [TDEST_WIDTH-1:0] dest_d [FLIT_BUFFER_DEPTH];
  logic [FLIT_BUFFER_DEPTH-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             credit_q, credit_d;
  pkt_state_e       state_q, state_d;
  logic             enq, deq, full;

  always_comb begin
    data_d   = data_q;
    dest_d   = dest_q;
    tail_d   = tail_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    full     = (count_q == CNT_FULL);
    deq      = (count_q != '0) && flit_ready;
    // A full buffer still accepts when the head leaves on the same edge.
    enq      = send_in && (!full || deq);
    credit_d = deq;
    if (enq) begin
      data_d[wr_ptr_q] = data_in;
      dest_d[wr_ptr_q] = dest_in;
      tail_d[wr_ptr_q] = is_tail_in;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (deq) begin
      case (state_q)
        IDLE:    if (!tail_q[rd_ptr_q]) state_d = BODY;
        BODY:    if (tail_q[rd_ptr_q])  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLIT_BUFFER_DEPTH; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
      end
      tail_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      state_q  <= IDLE;
    end else begin
      data_q   <= data_d;
      dest_q   <= dest_d;
      tail_q   <= tail_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      state_q  <= state_d;
    end
  end

  assign flit_valid = (count_q != '0);
  assign flit_data  = data_q[rd_ptr_q];
  assign flit_dest  = dest_q[rd_ptr_q];
  assign flit_tail  = tail_q[rd_ptr_q];
  assign flit_head  = (state_q == IDLE);
  assign credit_out = credit_q;

`ifdef NOC_FLIT_INGRESS_CHECK_EN
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_dest_q, err_dest_d;
  logic                   in_first_q, in_first_d;
  logic [TDEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;

  // Input-side tracker follows the sender's packet framing, independent of the buffer.
  always_comb begin
    err_overflow_d = err_overflow_q;
    err_dest_d     = err_dest_q;
    in_first_d     = in_first_q;
    pkt_dest_d     = pkt_dest_q;
    if (send_in && !enq) err_overflow_d = 1'b1;
    if (send_in) begin
      if (in_first_q) pkt_dest_d = dest_in;
      else if (dest_in != pkt_dest_q) err_dest_d = 1'b1;
      in_first_d = is_tail_in;
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q <= 1'b0;
      err_dest_q     <= 1'b0;
      in_first_q     <= 1'b1;
      pkt_dest_q     <= '0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_dest_q     <= err_dest_d;
      in_first_q     <= in_first_d;
      pkt_dest_q     <= pkt_dest_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_dest     = err_dest_q;
`else
  assign err_overflow = 1'b0;
  assign err_dest     = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_ingress_buffer.sv
// Directed + randomized bench for noc_flit_ingress_buffer with a scoreboard of expected output flits.
module tb_noc_flit_ingress_buffer;

  localparam int FW = 128;
  localparam int DW = 3;
  localparam int DEPTH = 4;
`ifdef NOC_FLIT_INGRESS_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk_noc = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_in;
  logic [DW-1:0] dest_in;
  logic          is_tail_in, send_in, credit_out, flit_valid, flit_ready;
  logic [FW-1:0] flit_data;
  logic [DW-1:0] flit_dest;
  logic          flit_tail, flit_head, err_overflow, err_dest;

  noc_flit_ingress_buffer #(.FLIT_WIDTH(FW), .TDEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
    .flit_dest(flit_dest), .flit_tail(flit_tail), .flit_head(flit_head),
    .err_overflow(err_overflow), .err_dest(err_dest));

  always #5 clk_noc = ~clk_noc;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [DW-1:0] dst;
    logic          t;
    logic          h;
  } flit_t;

  flit_t exp_q[$];
  logic  next_head = 1'b1;
  int    checks = 0, errors = 0;
  int    credit_cnt = 0, deq_cnt = 0;
  logic  deq_prev = 1'b0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t);
    flit_t f;
    f.d = d; f.dst = dst; f.t = t; f.h = next_head;
    exp_q.push_back(f);
    next_head = t;
  endtask

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t,
                           input bit push);
    data_in = d; dest_in = dst; is_tail_in = t; send_in = 1'b1;
    if (push) push_exp(d, dst, t);
    tick();
    send_in = 1'b0;
  endtask

  // Output monitor: credit timing against last cycle's handshake, and in-order flit contents.
  always @(negedge clk_noc) begin
    if (!rst_n) begin
      deq_prev = 1'b0;
    end else begin
      chk("credit_timing", FW'(credit_out), FW'(deq_prev));
      if (credit_out === 1'b1) credit_cnt++;
      deq_prev = (flit_valid === 1'b1) && flit_ready;
      if (deq_prev) begin
        deq_cnt++;
        chk("unexpected_flit", FW'(exp_q.size() != 0), FW'(1));
        if (exp_q.size() != 0) begin
          flit_t e;
          e = exp_q.pop_front();
          chk("out_data", flit_data, e.d);
          chk("out_dest", FW'(flit_dest), FW'(e.dst));
          chk("out_tail", FW'(flit_tail), FW'(e.t));
          chk("out_head", FW'(flit_head), FW'(e.h));
        end
      end
    end
  end

  int c0, d0, credits, sent, total, cyc;
  flit_t pkt_flits[$];

  initial begin
    rst_n = 1'b0; send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0; flit_ready = 1'b0;
    repeat (2) @(posedge clk_noc);
    #1;
    chk("rst_valid", FW'(flit_valid), FW'(0));
    chk("rst_credit", FW'(credit_out), FW'(0));
    chk("rst_head", FW'(flit_head), FW'(1));
    chk("rst_data", flit_data, '0);
    chk("rst_dest", FW'(flit_dest), FW'(0));
    chk("rst_tail", FW'(flit_tail), FW'(0));
    chk("rst_err_ovf", FW'(err_overflow), FW'(0));
    chk("rst_err_dest", FW'(err_dest), FW'(0));
    rst_n = 1'b1;
    tick();

    // T1: reset with three flits buffered mid-packet
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_flit(FW'(32'h10 + i), 3'd1, 1'b0, 1'b1);
    chk("t1_valid_pre", FW'(flit_valid), FW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid_async", FW'(flit_valid), FW'(0));
    chk("t1_credit_async", FW'(credit_out), FW'(0));
    chk("t1_head_async", FW'(flit_head), FW'(1));
    exp_q.delete();
    next_head = 1'b1;
    @(posedge clk_noc);
    #1 rst_n = 1'b1;
    c0 = credit_cnt;
    flit_ready = 1'b1;
    repeat (4) tick();
    chk("t1_no_credit", FW'(credit_cnt), FW'(c0));
    chk("t1_empty", FW'(flit_valid), FW'(0));

    // T2: single 4-flit packet, always ready
    c0 = credit_cnt; d0 = deq_cnt;
    data_in = FW'(1); dest_in = 3'd3; is_tail_in = 1'b0; send_in = 1'b1;
    push_exp(FW'(1), 3'd3, 1'b0);
    chk("t2_no_comb_path", FW'(flit_valid), FW'(0));
    tick();
    send_in = 1'b0;
    chk("t2_latency", FW'(flit_valid), FW'(1));
    send_flit(FW'(2), 3'd3, 1'b0, 1'b1);
    send_flit(FW'(3), 3'd3, 1'b0, 1'b1);
    send_flit(FW'(4), 3'd3, 1'b1, 1'b1);
    repeat (4) tick();
    chk("t2_credits", FW'(credit_cnt - c0), FW'(4));
    chk("t2_deqs", FW'(deq_cnt - d0), FW'(4));
    chk("t2_sb_empty", FW'(exp_q.size()), FW'(0));

    // T3: fill under backpressure, then enqueue on the first dequeue edge
    c0 = credit_cnt;
    flit_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_flit(FW'(i), 3'd1, 1'b0, 1'b1);
    tick();
    chk("t3_full_valid", FW'(flit_valid), FW'(1));
    chk("t3_no_credit", FW'(credit_cnt), FW'(c0));
    flit_ready = 1'b1;
    send_flit(FW'(5), 3'd1, 1'b1, 1'b1);
    repeat (8) tick();
    chk("t3_credits", FW'(credit_cnt - c0), FW'(5));
    chk("t3_sb_empty", FW'(exp_q.size()), FW'(0));

    // T4: overflow drop while full
    c0 = credit_cnt;
    flit_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_flit(FW'(32'h31 + i), 3'd4, i == 3, 1'b1);
    chk("t4_err_before", FW'(err_overflow), FW'(0));
    send_flit(FW'(32'hBAD), 3'd4, 1'b1, 1'b0);
    chk("t4_err_set", FW'(err_overflow), FW'(CHK));
    repeat (2) tick();
    chk("t4_err_sticky", FW'(err_overflow), FW'(CHK));
    flit_ready = 1'b1;
    repeat (8) tick();
    chk("t4_credits", FW'(credit_cnt - c0), FW'(4));
    chk("t4_sb_empty", FW'(exp_q.size()), FW'(0));
    chk("t4_drained", FW'(flit_valid), FW'(0));

    // T6: random packets, random backpressure, credit-limited sender
    pkt_flits.delete();
    for (int p = 0; p < 20; p++) begin
      int len;
      logic [DW-1:0] dst;
      len = $urandom_range(1, 4);
      dst = DW'($urandom_range(0, 7));
      for (int k = 0; k < len; k++) begin
        flit_t f;
        f.d = {$urandom, $urandom, $urandom, $urandom};
        f.dst = dst; f.t = (k == len - 1); f.h = 1'b0;
        pkt_flits.push_back(f);
      end
    end
    total = pkt_flits.size();
    c0 = credit_cnt; d0 = deq_cnt;
    credits = DEPTH; sent = 0; cyc = 0;
    while ((sent < total) && (cyc < 3000)) begin
      flit_ready = ($urandom_range(0, 2) != 0);
      if ((credits > 0) && ($urandom_range(0, 3) != 0)) begin
        data_in = pkt_flits[sent].d; dest_in = pkt_flits[sent].dst;
        is_tail_in = pkt_flits[sent].t; send_in = 1'b1;
        push_exp(pkt_flits[sent].d, pkt_flits[sent].dst, pkt_flits[sent].t);
        credits--; sent++;
      end else begin
        send_in = 1'b0;
      end
      tick();
      send_in = 1'b0;
      if (credit_out === 1'b1) credits++;
      cyc++;
    end
    chk("t6_all_sent", FW'(sent), FW'(total));
    flit_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (credit_out === 1'b1) credits++;
    end
    chk("t6_sb_empty", FW'(exp_q.size()), FW'(0));
    chk("t6_credits", FW'(credit_cnt - c0), FW'(total));
    chk("t6_deqs", FW'(deq_cnt - d0), FW'(total));
    chk("t6_sender_credits", FW'(credits), FW'(DEPTH));
    chk("t6_err_dest_clean", FW'(err_dest), FW'(0));

    // T5: destination changes on the tail flit
    flit_ready = 1'b1;
    send_flit(FW'(32'h51), 3'd2, 1'b0, 1'b1);
    send_flit(FW'(32'h52), 3'd2, 1'b0, 1'b1);
    chk("t5_err_before", FW'(err_dest), FW'(0));
    send_flit(FW'(32'h53), 3'd5, 1'b1, 1'b1);
    chk("t5_err_set", FW'(err_dest), FW'(CHK));
    repeat (4) tick();
    chk("t5_err_sticky", FW'(err_dest), FW'(CHK));
    chk("t5_sb_empty", FW'(exp_q.size()), FW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
